// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings and flit field-offset helpers.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'b00,
    FLIT_BODY     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  localparam int FLIT_TYPE_W = 2;

  // MSB index of the VC id field (VC id sits at the top of the flit).
  function automatic int vcid_msb(input int dw);
    return dw - 1;
  endfunction

  // MSB index of the flit type field, directly below the VC id.
  function automatic int type_msb(input int dw, input int vcid_w);
    return dw - vcid_w - 1;
  endfunction

  // True for flit types that close a packet and release the VC.
  function automatic logic is_tail(input logic [1:0] ftype);
    return (ftype == 2'(FLIT_TAIL)) || (ftype == 2'(FLIT_HEADTAIL));
  endfunction

endpackage

// File: rtl/out_vc_credit_chan.sv
// One virtual channel of an output port: credit counter, allocation-free flag
// and single-cycle error pulses for the top level to accumulate.
module out_vc_credit_chan #(
  parameter int BUF_DEPTH     = 8,
  parameter int CREDIT_LBOUND = 0,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic             send,
  input  logic             tail,
  input  logic             grant,
  output logic [CNT_W-1:0] credit,
  output logic             avail,
  output logic             ready,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             err_prot
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LB  = CNT_W'(CREDIT_LBOUND);

  logic [CNT_W-1:0] credit_r;
  logic [CNT_W-1:0] credit_nxt_s;
  logic             avail_r;
  logic             avail_nxt_s;

  // Credit next-state: a send and a return in the same cycle cancel out; saturate at the ends.
  always_comb begin
    credit_nxt_s = credit_r;
    err_ovf      = 1'b0;
    err_udf      = 1'b0;
    case ({send, upd})
      2'b10: begin
        if (credit_r == {CNT_W{1'b0}}) begin
          err_udf = 1'b1;
        end else begin
          credit_nxt_s = credit_r - CNT_W'(1);
        end
      end
      2'b01: begin
        if (credit_r == CNT_MAX) begin
          err_ovf = 1'b1;
        end else begin
          credit_nxt_s = credit_r + CNT_W'(1);
        end
      end
      default: credit_nxt_s = credit_r;
    endcase
  end

  // Availability next-state: a grant wins over a coinciding tail so back-to-back packets work.
  always_comb begin
    avail_nxt_s = avail_r;
    err_prot    = 1'b0;
    if (grant) begin
      avail_nxt_s = 1'b0;
      err_prot    = ~avail_r & ~tail;
    end else if (tail) begin
      avail_nxt_s = 1'b1;
    end else begin
      avail_nxt_s = avail_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= CNT_MAX;
      avail_r  <= 1'b1;
    end else begin
      credit_r <= credit_nxt_s;
      avail_r  <= avail_nxt_s;
    end
  end

  assign credit = credit_r;
  assign avail  = avail_r;
  assign ready  = (credit_r > CNT_LB);

endmodule

// File: rtl/output_port_vc_ctrl.sv
// Output-port VC controller: decodes the crossbar flit, registers credit returns,
// runs one credit/availability channel per VC and keeps sticky error flags.
module output_port_vc_ctrl
  import noc_pkg::*;
#(
  parameter int NUM_VC        = 4,
  parameter int BUF_DEPTH     = 8,
  parameter int CREDIT_LBOUND = 0,
  parameter int DW            = 32,
  parameter int VCID_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CNT_W         = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VC-1:0]       update,
  input  logic [NUM_VC-1:0]       outVCAvailableReset,
  input  logic                    valid,
  input  logic [DW-1:0]           dat,
  output logic [NUM_VC-1:0]       outVCAvailable,
  output logic [NUM_VC-1:0]       outVCReady,
  output logic [NUM_VC*CNT_W-1:0] creditCnt,
  output logic                    errOverflow,
  output logic                    errUnderflow,
  output logic                    errProtocol
);

  localparam int          VCID_MSB = vcid_msb(DW);
  localparam int          TYPE_MSB = type_msb(DW, VCID_W);
  localparam logic [31:0] NUM_VC_U = 32'(NUM_VC);

  logic [NUM_VC-1:0] update_q_r;
  logic [VCID_W-1:0] vcid_s;
  logic [1:0]        ftype_s;
  logic              vc_ok_s;
  logic              bad_vc_s;
  logic [NUM_VC-1:0] send_s;
  logic [NUM_VC-1:0] tail_send_s;
  logic [NUM_VC-1:0] ovf_s;
  logic [NUM_VC-1:0] udf_s;
  logic [NUM_VC-1:0] prot_s;
  logic              unused_payload_s;

  assign vcid_s           = dat[VCID_MSB -: VCID_W];
  assign ftype_s          = dat[TYPE_MSB -: FLIT_TYPE_W];
  assign unused_payload_s = ^dat[TYPE_MSB-FLIT_TYPE_W:0];

  // Flit decode: one-hot send per VC; an out-of-range VC id sends nowhere.
  always_comb begin
    vc_ok_s     = (32'(vcid_s) < NUM_VC_U);
    bad_vc_s    = valid & ~vc_ok_s;
    send_s      = {NUM_VC{1'b0}};
    tail_send_s = {NUM_VC{1'b0}};
    for (int v = 0; v < NUM_VC; v++) begin
      send_s[v]      = valid & vc_ok_s & (vcid_s == VCID_W'(v));
      tail_send_s[v] = send_s[v] & is_tail(ftype_s);
    end
  end

  // Credit returns are registered once before they reach the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_q_r <= {NUM_VC{1'b0}};
    end else begin
      update_q_r <= update;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_chan
    out_vc_credit_chan #(
      .BUF_DEPTH    (BUF_DEPTH),
      .CREDIT_LBOUND(CREDIT_LBOUND),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .upd     (update_q_r[v]),
      .send    (send_s[v]),
      .tail    (tail_send_s[v]),
      .grant   (outVCAvailableReset[v]),
      .credit  (creditCnt[v*CNT_W +: CNT_W]),
      .avail   (outVCAvailable[v]),
      .ready   (outVCReady[v]),
      .err_ovf (ovf_s[v]),
      .err_udf (udf_s[v]),
      .err_prot(prot_s[v])
    );
  end

  // Sticky error flags: any channel pulse latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      errOverflow  <= 1'b0;
      errUnderflow <= 1'b0;
      errProtocol  <= 1'b0;
    end else begin
      errOverflow  <= errOverflow  | (|ovf_s);
      errUnderflow <= errUnderflow | (|udf_s);
      errProtocol  <= errProtocol  | (|prot_s) | bad_vc_s;
    end
  end

endmodule
